// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator engine: op codes, FSM states and
// width helpers for decimal ranges.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExec,
        StConv,
        StDone
    } calc_state_e;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Bits needed to hold any value in [0, 10^n - 1], i.e. clog2(10^n).
    function automatic int unsigned pow10_width(input int unsigned n);
        longint unsigned p;
        longint unsigned one;
        int unsigned     w;
        p   = pow10(n);
        one = 1;
        w   = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((one << i) < p) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (double-dabble). The load cycle consumes the
// first bit, so a conversion spans RW cycles including the load.
module bin2bcd_serial #(
    parameter int unsigned RW         = 14,
    parameter int unsigned RES_DIGITS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [RW-1:0]             bin_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [4*RES_DIGITS-1:0]   bcd_o
);

    localparam int unsigned BW = 4 * RES_DIGITS;
    localparam int unsigned CW = $clog2(RW);

    logic [RW-1:0] sr_q;
    logic [BW-1:0] bcd_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] v, input logic bit_in);
        logic [BW-1:0] t;
        t = v;
        for (int i = 0; i < RES_DIGITS; i++) begin
            if (t[4*i +: 4] > 4'd4) begin
                t[4*i +: 4] = t[4*i +: 4] + 4'd3;
            end
        end
        return {t[BW-2:0], bit_in};
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                sr_q   <= {bin_i[RW-2:0], 1'b0};
                bcd_q  <= BW'(bin_i[RW-1]);
                cnt_q  <= CW'(RW - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q <= dabble(bcd_q, sr_q[RW-1]);
                sr_q  <= {sr_q[RW-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/bcd_calc_engine.sv
// Multi-cycle BCD arithmetic engine: serial BCD-to-binary load, shift-add
// multiply, restoring divide, then serial conversion back to BCD.
module bcd_calc_engine
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned FRAC   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [2:0]              op_i,
    input  logic [4*DIGITS-1:0]     a_bcd_i,
    input  logic [4*DIGITS-1:0]     b_bcd_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [8*DIGITS-1:0]     result_bcd_o,
    output logic                    negative_o,
    output logic [2:0]              dot_pos_o,
    output logic                    error_o
);

    localparam int unsigned OPW        = pow10_width(DIGITS);
    localparam int unsigned RW         = pow10_width(2 * DIGITS);
    localparam int unsigned RES_DIGITS = 2 * DIGITS;
    localparam int unsigned BW         = 4 * RES_DIGITS;
    localparam int unsigned CW         = $clog2(RW);

    localparam logic [OPW-1:0] TEN        = OPW'(10);
    localparam logic [RW-1:0]  FRAC_SCALE = RW'(pow10(FRAC));
    localparam logic [2:0]     DOT_DIV    = 3'(FRAC);

    calc_state_e           state_q;
    logic [2:0]            op_q;
    logic [4*DIGITS-1:0]   a_bcd_q;
    logic [4*DIGITS-1:0]   b_bcd_q;
    logic [OPW-1:0]        a_q;
    logic [OPW-1:0]        b_q;
    logic [OPW-1:0]        mplier_q;
    logic [RW-1:0]         acc_q;
    logic [RW-1:0]         rem_q;
    logic [RW-1:0]         mcand_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg_pend_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  neg_q;
    logic [BW-1:0]         result_q;
    logic [2:0]            dot_q;

    logic [3:0]            a_dig;
    logic [3:0]            b_dig;
    logic                  dig_bad;
    logic [OPW-1:0]        a_nxt;
    logic [OPW-1:0]        b_nxt;
    logic                  op_rsvd;
    logic                  div_zero;
    logic [RW-1:0]         prod_nxt;
    logic [RW:0]           rem_sh;
    logic                  rem_ge;
    logic [RW-1:0]         rem_nxt;
    logic [RW-1:0]         quo_nxt;
    logic [RW-1:0]         exec_res;
    logic                  exec_last;
    logic                  conv_load;
    logic                  conv_busy;
    logic                  conv_done;
    logic [BW-1:0]         conv_bcd;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_bcd_q[4*i +: 4];
                b_dig = b_bcd_q[4*i +: 4];
            end
        end
        dig_bad  = (a_dig > 4'd9) || (b_dig > 4'd9);
        a_nxt    = a_q * TEN + OPW'(a_dig);
        b_nxt    = b_q * TEN + OPW'(b_dig);
        op_rsvd  = op_q > OP_MOD;
        div_zero = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_nxt == '0);

        prod_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Dividend bits stream out of acc_q MSB first; quotient bits fill its LSBs.
        rem_sh   = {rem_q, acc_q[RW-1]};
        rem_ge   = rem_sh >= (RW+1)'(b_q);
        rem_nxt  = rem_ge ? (rem_sh[RW-1:0] - RW'(b_q)) : rem_sh[RW-1:0];
        quo_nxt  = {acc_q[RW-2:0], rem_ge};

        case (op_q)
            OP_ADD:  exec_res = RW'(a_q) + RW'(b_q);
            OP_SUB:  exec_res = (a_q < b_q) ? RW'(b_q - a_q) : RW'(a_q - b_q);
            OP_MUL:  exec_res = prod_nxt;
            OP_DIV:  exec_res = quo_nxt;
            OP_MOD:  exec_res = rem_nxt;
            default: exec_res = '0;
        endcase

        exec_last = (state_q == StExec) && (cnt_q == '0);
        conv_load = exec_last && !conv_busy;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= '0;
            a_bcd_q    <= '0;
            b_bcd_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            neg_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            neg_q      <= 1'b0;
            result_q   <= '0;
            dot_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        a_bcd_q <= a_bcd_i;
                        b_bcd_q <= b_bcd_i;
                        a_q     <= '0;
                        b_q     <= '0;
                        cnt_q   <= CW'(DIGITS - 1);
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    a_q   <= a_nxt;
                    b_q   <= b_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (dig_bad || ((cnt_q == '0) && (op_rsvd || div_zero))) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        error_q  <= 1'b1;
                        result_q <= '0;
                        neg_q    <= 1'b0;
                        dot_q    <= '0;
                    end else if (cnt_q == '0) begin
                        state_q    <= StExec;
                        neg_pend_q <= (op_q == OP_SUB) && (a_nxt < b_nxt);
                        mcand_q    <= RW'(a_nxt);
                        mplier_q   <= b_nxt;
                        rem_q      <= '0;
                        if (op_q == OP_DIV) begin
                            acc_q <= RW'(a_nxt) * FRAC_SCALE;
                        end else if (op_q == OP_MOD) begin
                            acc_q <= RW'(a_nxt);
                        end else begin
                            acc_q <= '0;
                        end
                        case (op_q)
                            OP_MUL:         cnt_q <= CW'(OPW - 1);
                            OP_DIV, OP_MOD: cnt_q <= CW'(RW - 1);
                            default:        cnt_q <= '0;
                        endcase
                    end
                end
                StExec: begin
                    cnt_q    <= cnt_q - CW'(1);
                    acc_q    <= (op_q == OP_MUL) ? prod_nxt : quo_nxt;
                    rem_q    <= rem_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (exec_last) begin
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        result_q <= conv_bcd;
                        neg_q    <= neg_pend_q;
                        dot_q    <= (op_q == OP_DIV) ? DOT_DIV : 3'd0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    bin2bcd_serial #(
        .RW         (RW),
        .RES_DIGITS (RES_DIGITS)
    ) u_bin2bcd (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (conv_load),
        .bin_i  (exec_res),
        .busy_o (conv_busy),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_bcd_o = result_q;
    assign negative_o   = neg_q;
    assign dot_pos_o    = dot_q;
    assign error_o      = error_q;

endmodule
